// File: rtl/bfxp_arbiter.sv
// bfxp_arbiter: round-robin front end for the shared bit-field extract/place unit.
// Grants one requester per cycle into a single registered result slot with backpressure.
module bfxp_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_rs1,
    input  logic [5*NREQ-1:0]    req_start,
    input  logic [5*NREQ-1:0]    req_len,
    input  logic [5*NREQ-1:0]    req_dest,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_rd,
    output logic                 busy
);

    logic [IDW-1:0] prio_ptr;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] ptr_next;
    logic           gnt_found;
    logic           can_issue;
    logic           handshake;
    int             cand;

    logic [31:0]    sel_rs1;
    logic [4:0]     sel_start;
    logic [4:0]     sel_len;
    logic [4:0]     sel_dest;
    logic [5:0]     src_end;
    logic [5:0]     dst_end;
    logic [4:0]     shamt;
    logic [63:0]    rot2;
    logic [31:0]    mask;
    logic [31:0]    op_result;

    // The result slot can take a new operation if empty or draining this edge.
    assign can_issue = !rsp_valid || rsp_ready;
    assign busy      = rsp_valid || (|req_valid);
    assign handshake = |req_ready;

    // Scan from prio_ptr upward, wrapping, for the first valid requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(prio_ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDW-1:0];
            end
        end
    end

    // One-hot accept, suppressed while stalled or in reset.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_found && can_issue && !reset && gnt_idx == IDW'(i)) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    // Route the winning requester's payload to the datapath.
    always_comb begin
        sel_rs1   = '0;
        sel_start = '0;
        sel_len   = '0;
        sel_dest  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_rs1   = req_rs1[32*i +: 32];
                sel_start = req_start[5*i +: 5];
                sel_len   = req_len[5*i +: 5];
                sel_dest  = req_dest[5*i +: 5];
            end
        end
    end

    // Extract/place: rotate the source field onto dest, then mask to the field.
    always_comb begin
        src_end = {1'b0, sel_start} + {1'b0, sel_len};
        dst_end = {1'b0, sel_dest} + {1'b0, sel_len};
        shamt   = sel_start - sel_dest;
        rot2    = {sel_rs1, sel_rs1} >> shamt;
        mask    = ((32'd1 << sel_len) - 32'd1) << sel_dest;
        if (src_end > 6'd32 || dst_end > 6'd32) begin
            op_result = '0;
        end else begin
            op_result = rot2[31:0] & mask;
        end
    end

    assign ptr_next = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

    // Result register and round-robin pointer; reset drops any pending result.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_rd    <= '0;
            prio_ptr  <= '0;
        end else if (handshake) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_idx;
            rsp_rd    <= op_result;
            prio_ptr  <= ptr_next;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bfxp_arbiter.sv
// tb_bfxp_arbiter: self-checking bench for bfxp_arbiter.
// Expected results are queued at acceptance and compared on delivery.
module tb_bfxp_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clock;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_rs1;
    logic [5*NREQ-1:0]   req_start;
    logic [5*NREQ-1:0]   req_len;
    logic [5*NREQ-1:0]   req_dest;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_rd;
    logic                busy;

    logic [31:0] rs1_a   [NREQ];
    logic [4:0]  start_a [NREQ];
    logic [4:0]  len_a   [NREQ];
    logic [4:0]  dest_a  [NREQ];

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    rd;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    bfxp_arbiter #(.NREQ(NREQ)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rs1   (req_rs1),
        .req_start (req_start),
        .req_len   (req_len),
        .req_dest  (req_dest),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_rd    (rsp_rd),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        req_rs1   = '0;
        req_start = '0;
        req_len   = '0;
        req_dest  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_rs1[32*i +: 32] = rs1_a[i];
            req_start[5*i +: 5] = start_a[i];
            req_len[5*i +: 5]   = len_a[i];
            req_dest[5*i +: 5]  = dest_a[i];
        end
    end

    // Bit-by-bit reference: copy len bits from start to dest.
    function automatic logic [31:0] model(input logic [31:0] rs1,
                                          input logic [4:0] s,
                                          input logic [4:0] l,
                                          input logic [4:0] d);
        int si, li, di;
        logic [31:0] r;
        si = int'(s);
        li = int'(l);
        di = int'(d);
        r = '0;
        if (si + li > 32 || di + li > 32) return 32'h0;
        for (int k = 0; k < li; k++) r[di + k] = rs1[si + k];
        return r;
    endfunction

    // Advance one clock; scoreboard pops delivered results, pushes accepted ones.
    task automatic cycle();
        exp_t e;
        @(negedge clock);
        if (reset) begin
            sb.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got id=%0d rd=%08h, required no response",
                             rsp_id, rsp_rd);
                end else begin
                    e = sb.pop_front();
                    if (rsp_id !== e.id || rsp_rd !== e.rd) begin
                        n_fail++;
                        $display("FAIL sb_result: got id=%0d rd=%08h, required id=%0d rd=%08h",
                                 rsp_id, rsp_rd, e.id, e.rd);
                    end
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id = IDW'(i);
                    e.rd = model(rs1_a[i], start_a[i], len_a[i], dest_a[i]);
                    sb.push_back(e);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] r,
                           input logic [4:0] s, input logic [4:0] l,
                           input logic [4:0] d);
        rs1_a[i]   = r;
        start_a[i] = s;
        len_a[i]   = l;
        dest_a[i]  = d;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        cycle();
        cycle();
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_rd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got v=%b id=%0d rd=%08h, required 0 0 0",
                     rsp_valid, rsp_id, rsp_rd);
        end
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, required 0000", req_ready);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy: got %b, required 1", busy);
        end
        req_valid = '0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy: got %b, required 0", busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_req(2, 32'h12345678, 5'd8, 5'd8, 5'd0);
        req_valid = 4'b0100;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_ready: got %b, required 0100", req_ready);
        end
        cycle();
        req_valid = '0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_rd !== 32'h00000056) begin
            n_fail++;
            $display("FAIL single_rsp: got v=%b id=%0d rd=%08h, required 1 2 00000056",
                     rsp_valid, rsp_id, rsp_rd);
        end
        req_valid = 4'b1111;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL single_ptr: got %b, required 1000", req_ready);
        end
        req_valid = '0;
        cycle();
    endtask

    task automatic test_place();
        set_req(0, 32'h12345678, 5'd4, 5'd12, 5'd16);
        req_valid = 4'b0001;
        cycle();
        req_valid = '0;
        n_checks++;
        if (rsp_rd !== 32'h05670000 || rsp_id !== 2'd0) begin
            n_fail++;
            $display("FAIL place: got id=%0d rd=%08h, required 0 05670000", rsp_id, rsp_rd);
        end
        cycle();
    endtask

    task automatic test_out_of_range();
        logic [4:0] s_t [4] = '{5'd28, 5'd0,  5'd5, 5'd28};
        logic [4:0] l_t [4] = '{5'd8,  5'd4,  5'd0, 5'd4};
        logic [4:0] d_t [4] = '{5'd3,  5'd30, 5'd3, 5'd0};
        logic [31:0] x_t [4] = '{32'h0, 32'h0, 32'h0, 32'h1};
        for (int c = 0; c < 4; c++) begin
            set_req(1, 32'h12345678, s_t[c], l_t[c], d_t[c]);
            req_valid = 4'b0010;
            cycle();
            req_valid = '0;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rd !== x_t[c]) begin
                n_fail++;
                $display("FAIL range_%0d: got v=%b rd=%08h, required 1 %08h",
                         c, rsp_valid, rsp_rd, x_t[c]);
            end
            cycle();
        end
        for (int c = 0; c < 12; c++) begin
            set_req(3, $urandom, 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 20)), 5'($urandom_range(0, 31)));
            req_valid = 4'b1000;
            cycle();
            req_valid = '0;
        end
        cycle();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 32'hA5C3_0F00 + 32'(i * 32'h1111), 5'(i * 3), 5'(4 + i), 5'(i * 5));
        end
        req_valid = '1;
        for (int n = 0; n < 12; n++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'(1 << (n % NREQ))) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: got %b, required %b",
                         n, req_ready, 4'(1 << (n % NREQ)));
            end
            cycle();
            n_checks++;
            if (rsp_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_valid_%0d: got %b, required 1", n, rsp_valid);
            end
        end
        req_valid = '0;
        cycle();
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        do_reset();
        req_valid = '1;
        cycle();
        held = model(rs1_a[0], start_a[0], len_a[0], dest_a[0]);
        rsp_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 ||
                rsp_id !== 2'd0 || rsp_rd !== held) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got rdy=%b v=%b id=%0d rd=%08h, required 0000 1 0 %08h",
                         n, req_ready, rsp_valid, rsp_id, rsp_rd, held);
            end
            cycle();
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_release: got %b, required 0010", req_ready);
        end
        cycle();
        req_valid = '0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_next: got v=%b id=%0d, required 1 1", rsp_valid, rsp_id);
        end
        cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = '1;
        cycle();
        cycle();
        reset     = 1'b1;
        rsp_ready = 1'b0;
        cycle();
        reset = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_valid: got %b, required 0", rsp_valid);
        end
        rsp_ready = 1'b1;
        req_valid = 4'b1010;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_reset_grant: got %b, required 0010", req_ready);
        end
        cycle();
        req_valid = '0;
        n_checks++;
        if (rsp_id !== 2'd1 || rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_rsp: got v=%b id=%0d, required 1 1", rsp_valid, rsp_id);
        end
        cycle();
        cycle();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'h0, 5'd0, 5'd0, 5'd0);
        test_reset();
        test_single();
        test_place();
        test_out_of_range();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d undelivered, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
